// File: rtl/assertion_fabric_cfg_ctrl.sv
// Assertion-fabric configuration controller: the host fills a shadow bank, and a commit copies it
// atomically to the fabric, flushes the fabric, and enables it only if the fabric reports a valid config.
module assertion_fabric_cfg_ctrl #(
    parameter int NUM_WORDS    = 40,
    parameter int ADDR_W       = 6,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [31:0]             wr_data,
    input  logic                    commit_req,
    output logic                    commit_ack,
    output logic                    commit_ok,
    input  logic                    cfg_invalid_i,
    output logic [NUM_WORDS*32-1:0] cfg_active,
    output logic                    fabric_rst,
    output logic                    fabric_enable,
    output logic                    busy,
    output logic                    addr_err
);

    localparam int              CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [ADDR_W:0] NW    = (ADDR_W + 1)'(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_ERROR, S_COMMIT, S_FLUSH, S_CHECK
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [NUM_WORDS-1:0][31:0]     shadow_q, shadow_d;
    logic [NUM_WORDS-1:0][31:0]     active_q, active_d;
    logic                           ack_q, ack_d;
    logic                           ok_q, ok_d;
    logic                           frst_q, frst_d;
    logic                           fen_q, fen_d;
    logic                           aerr_q, aerr_d;
    logic                           busy_c;
    logic                           wr_fire;

    assign busy_c  = (state_q == S_COMMIT) || (state_q == S_FLUSH) || (state_q == S_CHECK);
    assign wr_fire = wr_valid && !busy_c;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        ack_d    = 1'b0;
        ok_d     = ok_q;
        aerr_d   = aerr_q;

        // Shadow writes are blocked while a commit is in flight so the copied bank is stable.
        if (wr_fire) begin
            if ({1'b0, wr_addr} < NW) shadow_d[wr_addr] = wr_data;
            else                      aerr_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (commit_req) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                active_d = shadow_q;
                cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
                state_d  = S_FLUSH;
            end
            S_FLUSH: begin
                if (cnt_q == '0) state_d = S_CHECK;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_CHECK: begin
                ack_d = 1'b1;
                if (cfg_invalid_i) begin
                    state_d = S_ERROR;
                    ok_d    = 1'b0;
                end else begin
                    state_d = S_RUN;
                    ok_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Fabric controls are registered from the next state so they line up with the state itself.
        frst_d = !((state_d == S_RUN) || (state_d == S_CHECK));
        fen_d  = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            ack_q    <= 1'b0;
            ok_q     <= 1'b0;
            frst_q   <= 1'b1;
            fen_q    <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            ack_q    <= ack_d;
            ok_q     <= ok_d;
            frst_q   <= frst_d;
            fen_q    <= fen_d;
            aerr_q   <= aerr_d;
        end
    end

    assign wr_ready      = !busy_c;
    assign busy          = busy_c;
    assign commit_ack    = ack_q;
    assign commit_ok     = ok_q;
    assign cfg_active    = active_q;
    assign fabric_rst    = frst_q;
    assign fabric_enable = fen_q;
    assign addr_err      = aerr_q;

endmodule
